// File: rtl/issue_scoreboard.sv
// Dual-issue in-order scoreboard: tracks loads in flight and decides which decode slots issue.
// Optional performance counters are built only when ISSUE_PERF_CNT_EN is defined.
module issue_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id0_valid,
    input  logic        id1_valid,
    input  logic [4:0]  rs1_0_id,
    input  logic [4:0]  rs2_0_id,
    input  logic [4:0]  rd_0_id,
    input  logic [4:0]  rs1_1_id,
    input  logic [4:0]  rs2_1_id,
    input  logic [4:0]  rd_1_id,
    input  logic        use_rs1_0,
    input  logic        use_rs2_0,
    input  logic        reg_write_0,
    input  logic        is_load_0,
    input  logic        is_mem_0,
    input  logic        is_branch_0,
    input  logic        use_rs1_1,
    input  logic        use_rs2_1,
    input  logic        reg_write_1,
    input  logic        is_load_1,
    input  logic        is_mem_1,
    input  logic        is_branch_1,
    input  logic        lsu_wb_valid,
    input  logic [4:0]  lsu_wb_rd,
    input  logic        flush,
    output logic        issue0,
    output logic        issue1,
    output logic        id_stall,
    output logic        split,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_dual_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use_rs1;
        logic       use_rs2;
        logic       reg_write;
        logic       is_load;
        logic       is_mem;
    } slot_t;

    slot_t            slot0;
    slot_t            slot1;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             blocked0;
    logic             blocked1;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             pair_ok;
    logic             set0;
    logic             set1;
    logic             unused_ok;

    assign slot0 = '{valid: id0_valid, rs1: rs1_0_id, rs2: rs2_0_id, rd: rd_0_id,
                     use_rs1: use_rs1_0, use_rs2: use_rs2_0, reg_write: reg_write_0,
                     is_load: is_load_0, is_mem: is_mem_0};
    assign slot1 = '{valid: id1_valid, rs1: rs1_1_id, rs2: rs2_1_id, rd: rd_1_id,
                     use_rs1: use_rs1_1, use_rs2: use_rs2_1, reg_write: reg_write_1,
                     is_load: is_load_1, is_mem: is_mem_1};

    // A branch in the younger slot places no constraint on pairing.
    assign unused_ok = is_branch_1;

    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREGS);
    endfunction

    function automatic logic src_blocked(input logic [NREGS-1:0] vec,
                                         input logic use_src, input logic [4:0] idx);
        return use_src && in_range(idx) && vec[idx];
    endfunction

    function automatic logic slot_blocked(input logic [NREGS-1:0] vec, input slot_t s);
        return src_blocked(vec, s.use_rs1, s.rs1) || src_blocked(vec, s.use_rs2, s.rs2);
    endfunction

    always_comb begin
        blocked0   = slot_blocked(busy, slot0);
        blocked1   = slot_blocked(busy, slot1);
        // Slot1 may not read what slot0 writes this same cycle: there is no intra-pair forward.
        raw_hazard = slot0.reg_write && (slot0.rd != 5'd0) &&
                     ((slot1.use_rs1 && (slot1.rs1 == slot0.rd)) ||
                      (slot1.use_rs2 && (slot1.rs2 == slot0.rd)));
        waw_hazard = slot0.reg_write && slot1.reg_write &&
                     (slot0.rd != 5'd0) && (slot1.rd == slot0.rd);
        pair_ok    = !blocked1 && !raw_hazard && !waw_hazard &&
                     !(slot0.is_mem && slot1.is_mem) && !is_branch_0;

        issue0   = slot0.valid && !flush && !rst && !blocked0;
        issue1   = issue0 && slot1.valid && pair_ok;
        id_stall = slot0.valid && !issue0 && !flush && !rst;
        split    = issue0 && slot1.valid && !issue1;
    end

    assign set0 = issue0 && slot0.is_load && slot0.reg_write && in_range(slot0.rd);
    assign set1 = issue1 && slot1.is_load && slot1.reg_write && in_range(slot1.rd);

    // NOTE: every variable is given a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        busy_next = busy;
        if (lsu_wb_valid && in_range(lsu_wb_rd)) begin
            busy_next[lsu_wb_rd] = 1'b0;
        end
        // Applied after the writeback clear so a same-cycle re-issue of the load keeps the bit set.
        if (set0) begin
            busy_next[slot0.rd] = 1'b1;
        end
        if (set1) begin
            busy_next[slot1.rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] dual_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            dual_cnt_q  <= '0;
        end else begin
            if (id_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (issue1) begin
                dual_cnt_q <= dual_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_dual_cnt  = dual_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_dual_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios then random traffic against a
// queue-of-loads-in-flight reference model.
module tb_issue_scoreboard;

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, rw, ld, mem, br;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic        issue0, issue1, id_stall, split;
    logic [31:0] perf_stall_cnt, perf_dual_cnt;
    ins_t        s0, s1;

    int          n_checks = 0;
    int          n_errors = 0;

    bit [4:0]    inflight[$];
    int unsigned m_stall = 0;
    int unsigned m_dual  = 0;
    bit          e_i0, e_i1, e_stall, e_split;

    always #5 clk = ~clk;

    issue_scoreboard #(.NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .id0_valid(s0.v), .id1_valid(s1.v),
        .rs1_0_id(s0.rs1), .rs2_0_id(s0.rs2), .rd_0_id(s0.rd),
        .rs1_1_id(s1.rs1), .rs2_1_id(s1.rs2), .rd_1_id(s1.rd),
        .use_rs1_0(s0.u1), .use_rs2_0(s0.u2), .reg_write_0(s0.rw),
        .is_load_0(s0.ld), .is_mem_0(s0.mem), .is_branch_0(s0.br),
        .use_rs1_1(s1.u1), .use_rs2_1(s1.u2), .reg_write_1(s1.rw),
        .is_load_1(s1.ld), .is_mem_1(s1.mem), .is_branch_1(s1.br),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .flush(flush),
        .issue0(issue0), .issue1(issue1), .id_stall(id_stall), .split(split),
        .perf_stall_cnt(perf_stall_cnt), .perf_dual_cnt(perf_dual_cnt)
    );

    function automatic ins_t nop();
        ins_t i = '{default: 0};
        return i;
    endfunction

    function automatic ins_t alu(input bit [4:0] rd, input bit [4:0] a, input bit [4:0] b);
        ins_t i = nop();
        i.v = 1; i.rd = rd; i.rs1 = a; i.rs2 = b; i.u1 = 1; i.u2 = 1; i.rw = 1;
        return i;
    endfunction

    function automatic ins_t lw(input bit [4:0] rd, input bit [4:0] base);
        ins_t i = nop();
        i.v = 1; i.rd = rd; i.rs1 = base; i.u1 = 1; i.rw = 1; i.ld = 1; i.mem = 1;
        return i;
    endfunction

    function automatic ins_t sw(input bit [4:0] base, input bit [4:0] src);
        ins_t i = nop();
        i.v = 1; i.rs1 = base; i.rs2 = src; i.u1 = 1; i.u2 = 1; i.mem = 1;
        return i;
    endfunction

    function automatic ins_t beq(input bit [4:0] a, input bit [4:0] b);
        ins_t i = nop();
        i.v = 1; i.rs1 = a; i.rs2 = b; i.u1 = 1; i.u2 = 1; i.br = 1;
        return i;
    endfunction

    function automatic bit pending(input bit [4:0] r);
        foreach (inflight[k]) if (inflight[k] == r) return 1;
        return 0;
    endfunction

    function automatic bit waits(input bit use_src, input bit [4:0] r);
        return use_src && (r != 0) && pending(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, derive expectations from the rules, compare all outputs.
    task automatic settle(input string tag);
        bit dep, waw;
        #2;
        e_i0 = s0.v && !flush && !rst && !waits(s0.u1, s0.rs1) && !waits(s0.u2, s0.rs2);
        dep  = s0.rw && (s0.rd != 0) &&
               ((s1.u1 && s1.rs1 == s0.rd) || (s1.u2 && s1.rs2 == s0.rd));
        waw  = s0.rw && s1.rw && (s0.rd != 0) && (s1.rd == s0.rd);
        e_i1 = e_i0 && s1.v && !waits(s1.u1, s1.rs1) && !waits(s1.u2, s1.rs2) &&
               !dep && !waw && !(s0.mem && s1.mem) && !s0.br;
        e_stall = s0.v && !e_i0 && !flush && !rst;
        e_split = e_i0 && s1.v && !e_i1;
        check({tag, ".issue0"}, 32'(issue0), 32'(e_i0));
        check({tag, ".issue1"}, 32'(issue1), 32'(e_i1));
        check({tag, ".id_stall"}, 32'(id_stall), 32'(e_stall));
        check({tag, ".split"}, 32'(split), 32'(e_split));
`ifdef ISSUE_PERF_CNT_EN
        check({tag, ".perf_stall"}, perf_stall_cnt, m_stall);
        check({tag, ".perf_dual"}, perf_dual_cnt, m_dual);
`else
        check({tag, ".perf_stall"}, perf_stall_cnt, 32'd0);
        check({tag, ".perf_dual"}, perf_dual_cnt, 32'd0);
`endif
    endtask

    // Clock edge: retire written-back loads first, then record newly issued ones.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            m_stall = 0;
            m_dual  = 0;
        end else begin
            if (lsu_wb_valid) begin
                for (int k = inflight.size() - 1; k >= 0; k--)
                    if (inflight[k] == lsu_wb_rd) inflight.delete(k);
            end
            if (e_i0 && s0.ld && s0.rw && s0.rd != 0) inflight.push_back(s0.rd);
            if (e_i1 && s1.ld && s1.rw && s1.rd != 0) inflight.push_back(s1.rd);
            if (e_stall) m_stall++;
            if (e_i1) m_dual++;
        end
        #1;
        lsu_wb_valid = 0;
        flush        = 0;
    endtask

    function automatic ins_t rand_ins();
        ins_t i = nop();
        int   kind = $urandom_range(0, 4);
        bit [4:0] a = 5'($urandom_range(0, 7));
        bit [4:0] b = 5'($urandom_range(0, 7));
        bit [4:0] d = 5'($urandom_range(0, 7));
        case (kind)
            0: i = lw(d, a);
            1: i = sw(a, b);
            2: i = beq(a, b);
            default: i = alu(d, a, b);
        endcase
        i.v = ($urandom_range(0, 7) != 0);
        return i;
    endfunction

    initial begin
        rst = 1; flush = 0; lsu_wb_valid = 0; lsu_wb_rd = 0;
        s0 = nop(); s1 = nop();
        repeat (2) @(posedge clk);
        #1;
        s0 = alu(3, 1, 2);
        settle("reset_hold");
        check("reset_hold.issue0_lit", 32'(issue0), 32'd0);
        tick();
        rst = 0;

        // Load-use: one bubble, then the dependent add issues once the load writes back.
        s0 = lw(5, 1); s1 = nop();
        settle("lu_lw"); check("lu_lw.issue0_lit", 32'(issue0), 32'd1); tick();
        s0 = alu(6, 5, 1); lsu_wb_valid = 1; lsu_wb_rd = 5;
        settle("lu_bubble"); check("lu_bubble.stall_lit", 32'(id_stall), 32'd1); tick();
        settle("lu_issue"); check("lu_issue.issue0_lit", 32'(issue0), 32'd1);
`ifdef ISSUE_PERF_CNT_EN
        check("lu_issue.perf_stall_lit", perf_stall_cnt, 32'd1);
`endif
        tick();

        // Same-cycle RAW between slots splits the pair.
        s0 = alu(3, 1, 2); s1 = alu(4, 3, 1);
        settle("raw_split"); check("raw_split.split_lit", 32'(split), 32'd1); tick();

        // Independent pair dual-issues.
        s0 = alu(3, 1, 2); s1 = alu(7, 8, 9);
        settle("dual"); check("dual.issue1_lit", 32'(issue1), 32'd1); tick();
        settle("dual2"); tick();

        // Structural: two memory ops, and a branch in slot0.
        s0 = sw(1, 2); s1 = lw(10, 3);
        settle("memmem"); check("memmem.issue1_lit", 32'(issue1), 32'd0); tick();
        lsu_wb_valid = 1; lsu_wb_rd = 10;
        s0 = beq(1, 2); s1 = alu(11, 1, 2);
        settle("branch"); check("branch.issue1_lit", 32'(issue1), 32'd0); tick();

        // Writeback and re-issue of the same register in one cycle: the bit stays set.
        s0 = lw(5, 2); s1 = nop();
        settle("bz_lw1"); tick();
        lsu_wb_valid = 1; lsu_wb_rd = 5;
        settle("bz_lw2"); check("bz_lw2.issue0_lit", 32'(issue0), 32'd1); tick();
        s0 = alu(6, 5, 1);
        settle("bz_still_busy"); check("bz_still_busy.stall_lit", 32'(id_stall), 32'd1); tick();
        flush = 1;
        settle("flush");
        check("flush.issue0_lit", 32'(issue0), 32'd0);
        check("flush.stall_lit", 32'(id_stall), 32'd0);
        tick();
        settle("after_flush"); check("after_flush.stall_lit", 32'(id_stall), 32'd1); tick();
        lsu_wb_valid = 1; lsu_wb_rd = 5;
        settle("after_flush_wb"); tick();
        settle("after_flush_go"); check("after_flush_go.issue0_lit", 32'(issue0), 32'd1); tick();

        // Reset clears a pending load and the counters; coincident writeback is ignored.
        s0 = lw(9, 1); s1 = nop();
        settle("rs_lw9"); tick();
        s0 = alu(1, 9, 9); rst = 1; lsu_wb_valid = 1; lsu_wb_rd = 9;
        settle("rs_hold"); check("rs_hold.stall_lit", 32'(id_stall), 32'd0); tick();
        rst = 0;
        settle("rs_after");
        check("rs_after.issue0_lit", 32'(issue0), 32'd1);
        check("rs_after.perf_stall_lit", perf_stall_cnt, 32'd0);
        check("rs_after.perf_dual_lit", perf_dual_cnt, 32'd0);
        tick();

        // Random traffic over a small register window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            s0 = rand_ins(); s1 = rand_ins();
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) == 0) begin
                lsu_wb_valid = 1;
                lsu_wb_rd = (inflight.size() != 0 && $urandom_range(0, 3) != 0)
                          ? inflight[$urandom_range(0, inflight.size() - 1)]
                          : 5'($urandom_range(0, 7));
            end
            settle("rand");
            tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
